// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one requester at a time owns the shared
// resource for a whole burst of len+1 beats, after which priority rotates
// past it. A watchdog releases the resource if the owner stops making
// progress for TIMEOUT consecutive cycles.
module rr_burst_arbiter #(
  parameter  int N       = 4,
  parameter  int LEN_W   = 4,
  parameter  int TIMEOUT = 64,
  localparam int SEL_W   = (N > 1) ? $clog2(N) : 1,
  localparam int WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic               clk,
  input  logic               asrst,
  input  logic               en,
  input  logic [N-1:0]       req_vld,
  input  logic [N*LEN_W-1:0] req_len,
  input  logic               res_ready,
  output logic [N-1:0]       o_grant,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_busy,
  output logic               o_beat,
  output logic               o_last,
  output logic               o_done,
  output logic               o_abort
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  logic               pick_vld;
  logic [SEL_W-1:0]   pick_idx;
  int                 cand;
  logic               beat;
  logic               last_beat;
  logic               wd_expire;

  // Beat handshake with the current owner; only meaningful while busy.
  assign beat      = (state_q == BUSY) & req_vld[sel_q] & res_ready;
  assign last_beat = beat & (beat_cnt_q == len_q);
  assign wd_expire = (wdog_q == WD_W'(TIMEOUT - 1));

  // Round-robin pick: first requester scanning upward from last+1 (mod N).
  // Scanning offsets from far to near lets the nearest candidate win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last_q) + k) % N;
      if (req_vld[cand]) begin
        pick_vld = 1'b1;
        pick_idx = SEL_W'(cand);
      end
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge asrst) begin
    if (asrst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      wdog_q     <= '0;
      last_q     <= SEL_W'(N - 1);
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      wdog_q     <= wdog_d;
      last_q     <= last_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  // Next-state logic: grant from IDLE, release on last beat or watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en && pick_vld) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A final beat takes precedence over a coincident timeout.
        if (last_beat || (!beat && wd_expire)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: grant latch, beat counting, watchdog, pulses.
  always_comb begin
    grant_d    = grant_q;
    sel_d      = sel_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    wdog_d     = wdog_q;
    last_d     = last_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_vld) begin
          grant_d    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          sel_d      = pick_idx;
          len_d      = req_len[int'(pick_idx)*LEN_W +: LEN_W];
          beat_cnt_d = '0;
          wdog_d     = '0;
        end
      end
      BUSY: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          wdog_d     = '0;
          if (last_beat) begin
            grant_d    = '0;
            done_d     = 1'b1;
            last_d     = sel_q;
            beat_cnt_d = '0;
          end
        end else if (wd_expire) begin
          // Stalled owner loses its slot and drops to lowest priority.
          grant_d = '0;
          abort_d = 1'b1;
          last_d  = sel_q;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  // Outputs: registered owner/status, combinational beat strobes.
  always_comb begin
    o_grant = grant_q;
    o_sel   = sel_q;
    o_busy  = (state_q == BUSY);
    o_beat  = beat;
    o_last  = last_beat;
    o_done  = done_q;
    o_abort = abort_q;
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed testbench for rr_burst_arbiter. Inputs change right after the
// falling edge; outputs are sampled 1 time unit later.
module tb_rr_burst_arbiter;
  localparam int N       = 4;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int SEL_W   = 2;

  logic               clk = 1'b0;
  logic               asrst = 1'b1;
  logic               en = 1'b0;
  logic [N-1:0]       req_vld = '0;
  logic [N*LEN_W-1:0] req_len = '0;
  logic               res_ready = 1'b0;
  logic [N-1:0]       o_grant;
  logic [SEL_W-1:0]   o_sel;
  logic               o_busy, o_beat, o_last, o_done, o_abort;

  int checks = 0;
  int failures = 0;
  int beats;
  int bad;

  rr_burst_arbiter #(.N(N), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .asrst(asrst), .en(en), .req_vld(req_vld), .req_len(req_len),
    .res_ready(res_ready), .o_grant(o_grant), .o_sel(o_sel), .o_busy(o_busy),
    .o_beat(o_beat), .o_last(o_last), .o_done(o_done), .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    nxt();
    #1;
    check_val("rst_grant", o_grant, 0);
    check_val("rst_sel", o_sel, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_done_abort", {o_done, o_abort}, 0);

    // T1: single burst len=2 on requester 0
    nxt();
    asrst = 1'b0; en = 1'b1; req_vld = 4'b0001; req_len = 16'h0002; res_ready = 1'b1;
    #1;
    check_val("t1_c0_busy", o_busy, 0);
    for (int c = 1; c <= 4; c++) begin
      nxt();
      if (c == 4) req_vld = '0;
      #1;
      check_val($sformatf("t1_c%0d_grant", c), o_grant, (c < 4) ? 4'b0001 : 4'b0000);
      check_val($sformatf("t1_c%0d_beat", c), o_beat, (c < 4) ? 1 : 0);
      check_val($sformatf("t1_c%0d_last", c), o_last, (c == 3) ? 1 : 0);
      check_val($sformatf("t1_c%0d_done", c), o_done, (c == 4) ? 1 : 0);
    end

    // T2: all requesting, len=0, rotation with one-cycle bubble
    nxt(); asrst = 1'b1; #1;
    nxt(); asrst = 1'b0; req_vld = 4'b1111; req_len = '0; res_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      nxt();
      if (c == 10) req_vld = '0;
      #1;
      if (c % 2 == 1) begin
        check_val($sformatf("t2_c%0d_grant", c), o_grant, 32'(1) << (((c - 1) / 2) % 4));
        check_val($sformatf("t2_c%0d_sel", c), o_sel, ((c - 1) / 2) % 4);
      end else begin
        check_val($sformatf("t2_c%0d_grant", c), o_grant, 0);
        check_val($sformatf("t2_c%0d_done", c), o_done, 1);
      end
    end

    // T3: requester 1, len=3, res_ready toggling, len/req changes ignored
    nxt(); req_vld = 4'b0010; req_len = 16'h0030; res_ready = 1'b1;
    beats = 0;
    for (int c = 1; c <= 8; c++) begin
      nxt();
      res_ready = (c % 2 == 1);
      if (c == 2) begin req_len = '0; req_vld = 4'b0011; end
      if (c == 8) req_vld = '0;
      #1;
      beats += int'(o_beat);
      if (c < 8) check_val($sformatf("t3_c%0d_grant", c), o_grant, 4'b0010);
      if (c == 7) check_val("t3_last", o_last, 1);
      if (c == 8) begin
        check_val("t3_done", o_done, 1);
        check_val("t3_grant_clr", o_grant, 0);
      end
    end
    check_val("t3_beats", beats, 4);

    // T4: requester 2 stalls, watchdog aborts, requester 3 wins next
    nxt(); req_vld = 4'b0100; req_len = 16'h0500; res_ready = 1'b0;
    bad = 0;
    for (int c = 1; c <= 65; c++) begin
      nxt();
      if (c == 65) begin req_vld = 4'b1001; req_len = '0; res_ready = 1'b1; end
      #1;
      if (c <= 64 && (o_busy !== 1'b1 || o_abort !== 1'b0 || o_grant !== 4'b0100)) bad++;
      if (c == 65) begin
        check_val("t4_abort", o_abort, 1);
        check_val("t4_done", o_done, 0);
        check_val("t4_grant_clr", o_grant, 0);
      end
    end
    check_val("t4_hold_cycles_bad", bad, 0);
    nxt(); #1;
    check_val("t4_next_grant", o_grant, 4'b1000);
    check_val("t4_next_beat", o_beat, 1);
    nxt(); req_vld = '0; #1;
    check_val("t4_next_done", o_done, 1);

    // T4b: final beat on the timeout cycle wins over abort
    nxt(); req_vld = 4'b0001; req_len = '0; res_ready = 1'b0;
    for (int c = 1; c <= 65; c++) begin
      nxt();
      res_ready = (c == 64);
      if (c == 65) req_vld = '0;
      #1;
      if (c == 64) check_val("t4b_last", o_last, 1);
      if (c == 65) begin
        check_val("t4b_done", o_done, 1);
        check_val("t4b_abort", o_abort, 0);
      end
    end

    // T5: en dropped mid-burst, burst completes, no new grants while en=0
    nxt(); req_vld = 4'b0001; req_len = 16'h5555; en = 1'b1; res_ready = 1'b1;
    beats = 0;
    for (int c = 1; c <= 10; c++) begin
      nxt();
      if (c == 2) begin en = 1'b0; req_vld = 4'b1111; end
      #1;
      beats += int'(o_beat);
      if (c <= 6) check_val($sformatf("t5_c%0d_grant", c), o_grant, 4'b0001);
      if (c == 7) check_val("t5_done", o_done, 1);
      if (c >= 7) check_val($sformatf("t5_c%0d_idle", c), o_busy, 0);
    end
    check_val("t5_beats", beats, 6);
    nxt(); en = 1'b1; #1;
    check_val("t5_en_busy", o_busy, 0);
    nxt(); #1;
    check_val("t5_next_grant", o_grant, 4'b0010);

    // T6: asynchronous reset mid-burst, requester 0 wins afterwards
    nxt(); #1;
    check_val("t6_pre_busy", o_busy, 1);
    #2; asrst = 1'b1; #1;
    check_val("t6_rst_grant", o_grant, 0);
    check_val("t6_rst_busy_beat", {o_busy, o_beat}, 0);
    check_val("t6_rst_sel", o_sel, 0);
    nxt(); asrst = 1'b0; #1;
    check_val("t6_no_pulse", {o_done, o_abort}, 0);
    nxt(); #1;
    check_val("t6_first_grant", o_grant, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Round-robin burst arbiter sharing one downstream resource port (memory or bus slave) between `N` requesters. Unlike a per-cycle grant, the winner is locked for a whole burst of `len+1` beats, then priority rotates past it. A watchdog aborts a burst that stalls too long. It sits between the requester blocks and the shared resource, driving the resource mux select.

## Interface
- `N`, 4: number of requesters, 2..8.
- `LEN_W`, 4: burst-length field width; a burst is `len+1` beats (1..2^LEN_W).
- `TIMEOUT`, 64: cycles without a beat before a granted burst is aborted; must be ≥2.
- `clk`  in  1  clock, all state on rising edge.
- `asrst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  arbitration enable; gates new grants only.
- `req_vld`  in  N  per-requester request/beat-valid; held until granted burst completes.
- `req_len`  in  N*LEN_W  flattened burst lengths, requester i at `[i*LEN_W +: LEN_W]`; sampled at grant.
- `res_ready`  in  1  shared resource accepts a beat this cycle.
- `o_grant`  out  N  one-hot owner of the resource, registered.
- `o_sel`  out  clog2(N)  binary index of owner, registered, valid while `o_busy`.
- `o_busy`  out  1  burst in progress.
- `o_beat`  out  1  combinational: `o_busy & req_vld[o_sel] & res_ready`.
- `o_last`  out  1  combinational: `o_beat` and current beat is final.
- `o_done`  out  1  one-cycle pulse, registered, burst completed normally.
- `o_abort`  out  1  one-cycle pulse, registered, burst killed by watchdog.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if `en` and any `req_vld`, choose the first set bit scanning upward from `last+1` modulo N. Register `o_grant`, `o_sel` and `len`, clear the beat and watchdog counters, then go to BUSY. Otherwise stay.
- BUSY: each `o_beat` increments `beat_cnt` (width LEN_W) and clears the watchdog. Cycles without a beat increment the watchdog.
- On the beat where `beat_cnt == len` (`o_last`): go to IDLE, clear the grant, pulse `o_done`, and set `last := o_sel`.
- Watchdog reaches `TIMEOUT-1` with no beat: go to IDLE, clear the grant, pulse `o_abort`, and set `last := o_sel` so the staller loses priority.
- If the last beat and the timeout fall on the same cycle, the beat wins: `o_done` pulses and `o_abort` stays 0.
- `en` deassert in BUSY has no effect; the burst completes. `en` low in IDLE blocks new grants.
- The granted `req_vld` dropping mid-burst only stalls beats; it does not release the grant. Only completion or abort releases it.
- Requests from non-owners during BUSY are ignored and not queued; they are re-evaluated in IDLE.
- `req_len` changes after grant have no effect; the latched `len` is used.
- Wrap-around: pointer `last = N-1` makes requester 0 the highest priority next.

## Timing
- Reset values: `o_grant=0`, `o_sel=0`, `o_busy=0`, `o_done=0`, `o_abort=0`. Internal `last=N-1` so requester 0 wins first. Counters are 0.
- Request visible at cycle t in IDLE with `en=1` → `o_grant`/`o_busy` high from t+1. The first beat is possible at t+1.
- Last beat at cycle t → `o_grant=0`, `o_busy=0`, `o_done=1` at t+1.
- The earliest next grant is t+2, giving a fixed one-cycle bubble between bursts.
- Minimum burst occupancy is 1 beat, so the shortest request-to-done time is 2 cycles. Throughput is 1 beat/cycle while `res_ready` stays high.
- Abort: no beat for TIMEOUT consecutive BUSY cycles → `o_abort` high in the following cycle with the grant cleared.
- Reset asserted mid-burst forces all outputs to reset values immediately (asynchronous). No `o_done` or `o_abort` is emitted for that burst.

## Test plan
- Reset then `req_vld=4'b0001`, `len=2`, `res_ready=1` → `o_grant=0001` from cycle 1. Beats occur on cycles 1-3 with `o_last` on cycle 3, and `o_done` pulses on cycle 4.
- All four requesting continuously, `len=0`, `res_ready=1` → grants 0001, 0010, 0100, 1000, 0001 at every second cycle, each with a one-cycle gap.
- Requester 1 granted with `len=3`, `res_ready` toggling 1,0,1,0… → exactly 4 beats counted. `o_done` pulses the cycle after the 4th beat, and the grant stays stable throughout.
- `TIMEOUT=64`, requester 2 granted, `res_ready=0` → `o_abort` pulses 64 cycles after the last beat/grant, `o_done` stays 0, and requester 3 wins next if requesting.
- `en` dropped on cycle 2 of a `len=5` burst → the burst still completes 6 beats. No new grant is issued while `en=0`, even with `req_vld=1111`.
- `asrst` pulsed mid-burst → all outputs reach 0 within the same cycle. After release, requester 0 wins first.
